// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-to-decode queue bus
// Ports: flush, per-lane enqueue bundle (valid/pc/inst/pred_npc/gshare/bimodal/history),
//        in_ready, dequeue lanes (valid + same fields, lane 0 oldest), out_take, count.
interface fetch_buffer_if #(
    parameter int DEPTH     = 16,
    parameter int FETCH_W   = 2,
    parameter int DISP_W    = 2,
    parameter int HIST_BITS = 8
);
    logic                               flush;
    logic [FETCH_W-1:0]                 in_valid;
    logic [FETCH_W-1:0][31:0]           in_pc;
    logic [FETCH_W-1:0][31:0]           in_inst;
    logic [FETCH_W-1:0][31:0]           in_pred_npc;
    logic [FETCH_W-1:0]                 in_gshare_pred;
    logic [FETCH_W-1:0]                 in_bi_pred;
    logic [FETCH_W-1:0][HIST_BITS-1:0]  in_history;
    logic                               in_ready;
    logic [DISP_W-1:0]                  out_valid;
    logic [DISP_W-1:0][31:0]            out_pc;
    logic [DISP_W-1:0][31:0]            out_inst;
    logic [DISP_W-1:0][31:0]            out_pred_npc;
    logic [DISP_W-1:0]                  out_gshare_pred;
    logic [DISP_W-1:0]                  out_bi_pred;
    logic [DISP_W-1:0][HIST_BITS-1:0]   out_history;
    logic [$clog2(DISP_W+1)-1:0]        out_take;
    logic [$clog2(DEPTH+1)-1:0]         count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_pred_npc, in_gshare_pred, in_bi_pred,
               in_history, out_take,
        input  in_ready, out_valid, out_pc, out_inst, out_pred_npc, out_gshare_pred,
               out_bi_pred, out_history, count
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_pred_npc, in_gshare_pred, in_bi_pred,
               in_history, out_take,
        output in_ready, out_valid, out_pc, out_inst, out_pred_npc, out_gshare_pred,
               out_bi_pred, out_history, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction queue between fetch/prediction and decode
// Ports: clock, reset (async active-low), bus (fetch_buffer_if.slave: enqueue bundle,
//        dequeue lanes, out_take, flush, in_ready, count).
module fetch_buffer #(
    parameter int DEPTH     = 16,
    parameter int FETCH_W   = 2,
    parameter int DISP_W    = 2,
    parameter int HIST_BITS = 8
) (
    input logic           clock,
    input logic           reset,
    fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          pred_npc;
        logic                 gshare_pred;
        logic                 bi_pred;
        logic [HIST_BITS-1:0] history;
    } entry_t;

    entry_t                       mem [DEPTH];
    logic [AW-1:0]                head, tail;
    logic [CW-1:0]                count, enq_num, take, eff_take;
    logic [FETCH_W-1:0][AW-1:0]   slot;
    logic                         ready, enq;

    // Ready looks only at registered occupancy so it never depends on decode this cycle.
    assign ready        = count <= CW'(DEPTH - FETCH_W);
    assign enq          = ready && |bus.in_valid && !bus.flush;
    assign take         = CW'(bus.out_take);
    assign eff_take     = take > count ? count : take;
    assign bus.in_ready = ready;
    assign bus.count    = count;

    // Compact sparse lanes: each valid lane lands after all lower valid lanes.
    always_comb begin
        enq_num = '0;
        slot    = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot[i] = tail + enq_num[AW-1:0];
            enq_num = enq_num + CW'(bus.in_valid[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + eff_take[AW-1:0];
            tail  <= tail + (enq ? enq_num[AW-1:0] : '0);
            count <= count + (enq ? enq_num : '0) - eff_take;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_W; i++)
            if (enq && bus.in_valid[i])
                mem[slot[i]] <= '{pc: bus.in_pc[i], inst: bus.in_inst[i],
                                  pred_npc: bus.in_pred_npc[i],
                                  gshare_pred: bus.in_gshare_pred[i],
                                  bi_pred: bus.in_bi_pred[i], history: bus.in_history[i]};
    end

    for (genvar k = 0; k < DISP_W; k++) begin : g_out
        assign bus.out_valid[k]       = count > CW'(k);
        assign bus.out_pc[k]          = mem[head + AW'(k)].pc;
        assign bus.out_inst[k]        = mem[head + AW'(k)].inst;
        assign bus.out_pred_npc[k]    = mem[head + AW'(k)].pred_npc;
        assign bus.out_gshare_pred[k] = mem[head + AW'(k)].gshare_pred;
        assign bus.out_bi_pred[k]     = mem[head + AW'(k)].bi_pred;
        assign bus.out_history[k]     = mem[head + AW'(k)].history;
    end
endmodule
